// File: rtl/aes_key_schedule_if.sv
// Key-load handshake and round-key read port of the AES key-schedule block.
interface aes_key_schedule_if #(
  parameter int KEY_BITS = 128
);
  logic                key_valid;
  logic                key_ready;
  logic [KEY_BITS-1:0] key_in;
  logic [3:0]          rk_idx;
  logic [127:0]        rk_out;
  logic                busy;
  logic                done;

  modport master (
    output key_valid, key_in, rk_idx,
    input  key_ready, rk_out, busy, done
  );

  modport slave (
    input  key_valid, key_in, rk_idx,
    output key_ready, rk_out, busy, done
  );
endinterface

// File: rtl/aes_key_schedule.sv
// Iterative AES key expansion (128/192/256-bit keys): one schedule word per
// clock into a local word store, read back as 128-bit round keys.
module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input logic             clk,
  input logic             rst_n,
  aes_key_schedule_if.slave bus
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] LAST_W   = 6'(NW - 1);
  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [2:0] POS_LAST = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $fatal(1, "aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  // FIPS-197 S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t      state;
  logic [5:0]  i;      // index of the next word to produce
  logic [2:0]  pos;    // i mod NK, kept as a counter to avoid a divider
  logic [7:0]  rcon;
  logic [31:0] w [NW];
  logic        accept;
  logic [31:0] prev;
  logic [31:0] temp;
  logic [31:0] next_word;
  logic [5:0]  base;

  // key_ready is low only in EXPAND, so this also masks key_valid there.
  assign accept = bus.key_valid && bus.key_ready;
  assign base   = {bus.rk_idx, 2'b00};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    prev = w[i - 6'd1];
    temp = prev;
    if (pos == 3'd0) begin
      temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
    end else if (NK == 8 && pos == 3'd4) begin
      temp = sub_word(prev);
    end
    next_word = w[i - NK_W] ^ temp;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.key_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      i             <= '0;
      pos           <= '0;
      rcon          <= 8'h01;
    end else begin
      case (state)
        IDLE, READY: begin
          if (accept) begin
            state         <= EXPAND;
            bus.key_ready <= 1'b0;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            i             <= NK_W;
            pos           <= '0;
            rcon          <= 8'h01;
          end
        end
        EXPAND: begin
          if (pos == 3'd0) rcon <= xtime(rcon);
          pos <= (pos == POS_LAST) ? 3'd0 : pos + 3'd1;
          i   <= i + 6'd1;
          if (i == LAST_W) begin
            state         <= READY;
            bus.key_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the word store has no reset; done qualifies its contents, and skipping reset keeps it RAM-friendly.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < NK; j++) begin
        w[j] <= bus.key_in[KEY_BITS-1-32*j -: 32];
      end
    end else if (state == EXPAND) begin
      w[i] <= next_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rk_out <= '0;
    end else if (bus.rk_idx > NR_IDX) begin
      bus.rk_out <= '0;
    end else begin
      bus.rk_out <= {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 vectors for all key sizes,
// re-key while busy, reset mid-expansion and a READY round-key sweep.
module tb_aes_key_schedule;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_schedule_if #(.KEY_BITS(128)) if128 ();
  aes_key_schedule_if #(.KEY_BITS(192)) if192 ();
  aes_key_schedule_if #(.KEY_BITS(256)) if256 ();

  aes_key_schedule #(.KEY_BITS(128)) dut128 (.clk(clk), .rst_n(rst_n), .bus(if128));
  aes_key_schedule #(.KEY_BITS(192)) dut192 (.clk(clk), .rst_n(rst_n), .bus(if192));
  aes_key_schedule #(.KEY_BITS(256)) dut256 (.clk(clk), .rst_n(rst_n), .bus(if256));

  localparam logic [255:0] KEY_A   = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY_B   = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY_192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY_256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] RK_A [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] RK_B1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] RK_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct packed {
    logic         ready;
    logic         busy;
    logic         done;
    logic [127:0] rk;
  } status_t;

  typedef struct {
    int           d;      // 0: 128-bit DUT, 1: 192-bit, 2: 256-bit
    logic [255:0] key;
    logic [3:0]   idx;
    logic [127:0] exp_rk;
    string        name;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] loaded [3];
  vec_t vecs [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic v, input logic [255:0] k);
    case (d)
      0: begin if128.key_valid = v; if128.key_in = k[127:0]; end
      1: begin if192.key_valid = v; if192.key_in = k[191:0]; end
      default: begin if256.key_valid = v; if256.key_in = k; end
    endcase
  endtask

  task automatic set_idx(input int d, input logic [3:0] idx);
    case (d)
      0: if128.rk_idx = idx;
      1: if192.rk_idx = idx;
      default: if256.rk_idx = idx;
    endcase
  endtask

  function automatic status_t status(input int d);
    case (d)
      0: return '{if128.key_ready, if128.busy, if128.done, if128.rk_out};
      1: return '{if192.key_ready, if192.busy, if192.done, if192.rk_out};
      default: return '{if256.key_ready, if256.busy, if256.done, if256.rk_out};
    endcase
  endfunction

  function automatic int exp_latency(input int d);
    case (d)
      0: return 40;
      1: return 46;
      default: return 52;
    endcase
  endfunction

  // Ticks until done rises, bounded; returns the number of edges taken.
  task automatic wait_done(input int d, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!status(d).done && cnt < 200);
  endtask

  task automatic load_key(input int d, input logic [255:0] k);
    int cnt;
    set_in(d, 1'b1, k);
    check($sformatf("ready_before_load_d%0d", d), 128'(status(d).ready), 128'd1);
    tick();
    set_in(d, 1'b0, k);
    check($sformatf("busy_after_accept_d%0d", d), 128'(status(d).busy), 128'd1);
    check($sformatf("ready_low_in_expand_d%0d", d), 128'(status(d).ready), 128'd0);
    check($sformatf("done_low_after_accept_d%0d", d), 128'(status(d).done), 128'd0);
    wait_done(d, cnt);
    check($sformatf("latency_d%0d", d), 128'(cnt), 128'(exp_latency(d)));
    check($sformatf("busy_low_in_ready_d%0d", d), 128'(status(d).busy), 128'd0);
    loaded[d] = k;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int d = 0; d < 3; d++) begin
      set_in(d, 1'b0, '0);
      set_idx(d, 4'd0);
      loaded[d] = '1;
    end

    vecs.push_back('{0, KEY_A,   4'd0,  RK_A[0],  "a128_rk0"});
    vecs.push_back('{0, KEY_A,   4'd1,  RK_A[1],  "a128_rk1"});
    vecs.push_back('{0, KEY_A,   4'd2,  RK_A[2],  "a128_rk2"});
    vecs.push_back('{0, KEY_A,   4'd10, RK_A[10], "a128_rk10"});
    vecs.push_back('{0, KEY_A,   4'd11, 128'h0,   "a128_rk11_zero"});
    vecs.push_back('{0, KEY_A,   4'd15, 128'h0,   "a128_rk15_zero"});
    vecs.push_back('{1, KEY_192, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5, "k192_rk0"});
    vecs.push_back('{1, KEY_192, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, "k192_rk1"});
    vecs.push_back('{1, KEY_192, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "k192_rk12"});
    vecs.push_back('{1, KEY_192, 4'd13, 128'h0, "k192_rk13_zero"});
    vecs.push_back('{2, KEY_256, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781, "k256_rk0"});
    vecs.push_back('{2, KEY_256, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4, "k256_rk1"});
    vecs.push_back('{2, KEY_256, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "k256_rk14"});
    vecs.push_back('{2, KEY_256, 4'd15, 128'h0, "k256_rk15_zero"});
    vecs.push_back('{0, KEY_B,   4'd0,  KEY_B[127:0], "b128_rk0"});
    vecs.push_back('{0, KEY_B,   4'd1,  RK_B1,  "b128_rk1"});
    vecs.push_back('{0, KEY_B,   4'd10, RK_B10, "b128_rk10"});

    // Reset state, sampled while rst_n is still low.
    #12;
    check("rst_busy", 128'(if128.busy), 128'd0);
    check("rst_done", 128'(if128.done), 128'd0);
    check("rst_rk_out", if128.rk_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 128'(if128.key_ready), 128'd1);

    foreach (vecs[k]) begin
      if (loaded[vecs[k].d] !== vecs[k].key) load_key(vecs[k].d, vecs[k].key);
      set_idx(vecs[k].d, vecs[k].idx);
      tick();
      check(vecs[k].name, status(vecs[k].d).rk, vecs[k].exp_rk);
    end

    // Second key held valid throughout EXPAND is ignored, then taken in READY.
    set_idx(0, 4'd10);
    set_in(0, 1'b1, KEY_A);
    tick();
    set_in(0, 1'b1, KEY_B);
    wait_done(0, cnt);
    check("hold_first_latency", 128'(cnt), 128'd40);
    tick();
    set_in(0, 1'b0, KEY_B);
    check("hold_done_drops", 128'(if128.done), 128'd0);
    check("hold_busy_restart", 128'(if128.busy), 128'd1);
    check("hold_first_rk10", if128.rk_out, RK_A[10]);
    wait_done(0, cnt);
    check("hold_second_latency", 128'(cnt), 128'd40);
    tick();
    check("hold_second_rk10", if128.rk_out, RK_B10);
    set_idx(0, 4'd1);
    tick();
    check("hold_second_rk1", if128.rk_out, RK_B1);

    // Reset pulsed 20 cycles into an expansion aborts it at once.
    set_idx(0, 4'd10);
    set_in(0, 1'b1, KEY_A);
    tick();
    set_in(0, 1'b0, KEY_A);
    repeat (19) tick();
    check("abort_busy_before", 128'(if128.busy), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(if128.busy), 128'd0);
    check("abort_done", 128'(if128.done), 128'd0);
    check("abort_rk_out", if128.rk_out, 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    loaded[0] = '1;
    load_key(0, KEY_A);

    // READY sweep: each index shows up exactly one edge later.
    for (int j = 0; j < 16; j++) begin
      set_idx(0, 4'(j));
      tick();
      check($sformatf("sweep_idx%0d", j), if128.rk_out, (j <= 10) ? RK_A[j] : 128'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
